// File: rtl/acc_job_arbiter.sv
// acc_job_arbiter
//   Round-robin arbiter sharing one accumulator (Load / Data_In / Done /
//   ACC_Out handshake) among four requesters. One job at a time: grant,
//   launch, wait for the Done rising edge, return the result with a
//   one-cycle Ack to the owner.
//
//   Optional feature: define ACC_ARB_TIMEOUT_EN to abort a job after
//   TIMEOUT WAIT cycles (Result=0, Err=1, Acc_Reset low for the RESP cycle).
//
// Ports
//   Clk, Reset      clock (rising edge), async active-low reset
//   Req, Req_Data   per-requester level request + packed operands
//   Grant, Ack      one-hot owner (LOAD..RESP), one-cycle completion pulse
//   Result, Err     job result (valid in Ack cycle, held), timeout flag
//   Acc_Load        one-cycle launch pulse to the accumulator
//   Acc_Data        operand, stable for the whole job
//   Acc_Reset       active-low accumulator reset (timeout recovery)
//   Acc_Done        accumulator completion level
//   Acc_Out         accumulator result
module acc_job_arbiter #(
   parameter int DATA_W  = 8,
   parameter int TIMEOUT = 255
) (
   input  logic                  Clk,
   input  logic                  Reset,
   input  logic [3:0]            Req,
   input  logic [4*DATA_W-1:0]   Req_Data,
   output logic [3:0]            Grant,
   output logic [3:0]            Ack,
   output logic [DATA_W-1:0]     Result,
   output logic                  Err,
   output logic                  Acc_Load,
   output logic [DATA_W-1:0]     Acc_Data,
   output logic                  Acc_Reset,
   input  logic                  Acc_Done,
   input  logic [DATA_W-1:0]     Acc_Out
);

   localparam int NUM_REQ = 4;

   typedef enum logic [1:0] {IDLE, LOAD, WAIT, RESP} state_t;

   state_t       state;
   logic [1:0]   last;      // previous owner; search starts one above it
   logic [1:0]   own;       // current owner index
   logic         done_q;    // Acc_Done delayed, for edge detection
   logic         sel_vld;
   logic [1:0]   sel;
   logic         done_rise;

   // Round-robin pick: first set Req bit at (last+1), (last+2), ... with wrap.
   // k = NUM_REQ lands back on last itself, so a lone re-request by the
   // previous owner is still served.
   always_comb begin
      sel_vld = 1'b0;
      sel     = last;
      for (int k = 1; k <= NUM_REQ; k++) begin
         logic [1:0] idx;
         idx = last + 2'(k);
         if (!sel_vld && Req[idx]) begin
            sel_vld = 1'b1;
            sel     = idx;
         end
      end
   end

   // A Done level still high from an earlier job must not finish a new one.
   assign done_rise = Acc_Done & ~done_q;

`ifdef ACC_ARB_TIMEOUT_EN
   localparam int CNT_W = $clog2(TIMEOUT + 1);
   logic [CNT_W-1:0] cnt;
`else
   assign Err       = 1'b0;
   assign Acc_Reset = 1'b1;
`endif

   always_ff @(posedge Clk or negedge Reset) begin
      if (!Reset) begin
         state     <= IDLE;
         Grant     <= '0;
         Ack       <= '0;
         Result    <= '0;
         Acc_Load  <= 1'b0;
         Acc_Data  <= '0;
         last      <= 2'd3;
         own       <= 2'd0;
         done_q    <= 1'b0;
`ifdef ACC_ARB_TIMEOUT_EN
         Err       <= 1'b0;
         Acc_Reset <= 1'b1;
         cnt       <= '0;
`endif
      end else begin
         done_q   <= Acc_Done;
         Ack      <= '0;
         Acc_Load <= 1'b0;
`ifdef ACC_ARB_TIMEOUT_EN
         Err       <= 1'b0;
         Acc_Reset <= 1'b1;
`endif
         case (state)
            IDLE: begin
               if (sel_vld) begin
                  Grant    <= 4'b0001 << sel;
                  own      <= sel;
                  Acc_Data <= Req_Data[int'(sel)*DATA_W +: DATA_W];
                  Acc_Load <= 1'b1;
                  state    <= LOAD;
               end
            end
            LOAD: begin
`ifdef ACC_ARB_TIMEOUT_EN
               cnt <= '0;
`endif
               state <= WAIT;
            end
            WAIT: begin
               if (done_rise) begin
                  Result <= Acc_Out;
                  Ack    <= Grant;
                  state  <= RESP;
               end
`ifdef ACC_ARB_TIMEOUT_EN
               else begin
                  // cnt counts completed WAIT cycles; abort once this one
                  // brings it to TIMEOUT.
                  cnt <= cnt + 1'b1;
                  if (cnt + 1'b1 == CNT_W'(TIMEOUT)) begin
                     Result    <= '0;
                     Ack       <= Grant;
                     Err       <= 1'b1;
                     Acc_Reset <= 1'b0;
                     state     <= RESP;
                  end
               end
`endif
            end
            RESP: begin
               Grant <= '0;
               last  <= own;
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_acc_job_arbiter.sv
module tb_acc_job_arbiter;

   localparam int DW = 8;
`ifdef ACC_ARB_TIMEOUT_EN
   localparam int TO = 8;
`else
   localparam int TO = 255;
`endif

   logic            Clk = 1'b0;
   logic            Reset = 1'b0;
   logic [3:0]      Req = '0;
   logic [4*DW-1:0] Req_Data = '0;
   logic            Acc_Done = 1'b0;
   logic [DW-1:0]   Acc_Out = '0;
   logic [3:0]      Grant, Ack;
   logic [DW-1:0]   Result, Acc_Data;
   logic            Err, Acc_Load, Acc_Reset;

   acc_job_arbiter #(.DATA_W(DW), .TIMEOUT(TO)) dut (
      .Clk(Clk), .Reset(Reset), .Req(Req), .Req_Data(Req_Data),
      .Grant(Grant), .Ack(Ack), .Result(Result), .Err(Err),
      .Acc_Load(Acc_Load), .Acc_Data(Acc_Data), .Acc_Reset(Acc_Reset),
      .Acc_Done(Acc_Done), .Acc_Out(Acc_Out)
   );

   always #5 Clk = ~Clk;

   int cyc = 0;
   always @(posedge Clk) cyc <= cyc + 1;

   int vectors = 0;
   int errors  = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   // ---------------- accumulator stand-in ----------------
   // Done rises acc_delay cycles after the Load cycle; result = operand*6.
   // stale=1 keeps the old Done high for a while, drops it, then raises it.
   int        acc_delay = 6;
   bit        stale = 1'b0;
   int        acc_cnt = 0;
   logic [7:0] acc_op = '0;

   initial forever begin
      @(posedge Clk);
      #2;
      if (!Reset) acc_cnt = 0;
      else if (Acc_Load) begin
         acc_cnt = acc_delay;
         acc_op  = Acc_Data;
         if (!stale) Acc_Done = 1'b0;
      end else if (acc_cnt > 0) begin
         acc_cnt--;
         if (acc_cnt == 0) begin
            Acc_Done = 1'b1;
            Acc_Out  = 8'(acc_op * 8'd6);
         end else if (stale && acc_cnt == 2) Acc_Done = 1'b0;
      end
   end

   // ---------------- job-level model + per-cycle compare ----------------
   // A job is described by its grant cycle m_t0 and the cycle m_dt in which
   // its completion (Done edge or timeout) was seen; every output follows
   // from those two numbers.
   bit         m_act = 1'b0;
   int         m_t0 = 0, m_dt = -1, m_own = 0, m_last = 3;
   logic [7:0] m_data = '0, m_res = '0, m_pend = '0;
   bit         m_to = 1'b0, m_prev = 1'b0;
   int         gq[$];

   initial forever begin
      logic [3:0] eg, eack;
      bit         eload, eerr;
      @(negedge Clk);
      if (!Reset) begin
         m_act = 0; m_last = 3; m_data = '0; m_res = '0; m_pend = '0;
         m_prev = 0; m_to = 0; m_dt = -1;
      end
      eg    = m_act ? 4'(1 << m_own) : 4'b0;
      eack  = (m_act && m_dt >= 0 && cyc == m_dt + 1) ? eg : 4'b0;
      eload = m_act && cyc == m_t0;
      eerr  = (eack != 0) && m_to;
      if (eack != 0) m_res = m_pend;
      chk("grant",     Grant,     eg);
      chk("ack",       Ack,       eack);
      chk("acc_load",  Acc_Load,  eload);
      chk("acc_data",  Acc_Data,  m_data);
      chk("result",    Result,    m_res);
      chk("err",       Err,       eerr);
      chk("acc_reset", Acc_Reset, !eerr);
      if (eload) gq.push_back(m_own);
      if (Reset) begin
         if (m_act) begin
            if (m_dt >= 0 && cyc == m_dt + 1) begin
               m_act = 0; m_last = m_own;
            end else if (m_dt < 0 && cyc > m_t0) begin
               if (Acc_Done && !m_prev) begin
                  m_dt = cyc; m_pend = Acc_Out; m_to = 0;
               end
`ifdef ACC_ARB_TIMEOUT_EN
               else if (cyc - m_t0 == TO) begin
                  m_dt = cyc; m_pend = '0; m_to = 1;
               end
`endif
            end
         end else if (Req != 0) begin
            for (int k = 1; k <= 4; k++) begin
               int o;
               o = (m_last + k) % 4;
               if (!m_act && Req[o]) begin
                  m_act = 1; m_own = o; m_t0 = cyc + 1; m_dt = -1;
                  m_data = Req_Data[o*8 +: 8];
               end
            end
         end
         m_prev = Acc_Done;
      end
   end

   // ---------------- directed stimulus ----------------
   task automatic wait_ack(input string nm, input int max, output int c);
      c = -1;
      for (int i = 0; i < max; i++) begin
         @(negedge Clk);
         if (Ack != 0) begin
            c = cyc;
            return;
         end
      end
      vectors++;
      errors++;
      $display("FAIL %s: no Ack within %0d cycles", nm, max);
   endtask

   task automatic step();
      @(posedge Clk);
      #1;
   endtask

   initial begin
      int t_req, t_ack, own;
      int exp_ord[5] = '{0, 1, 2, 3, 0};
      logic [7:0] exp_res[5] = '{8'h60, 8'hC0, 8'h20, 8'h80, 8'h60};
      logic [7:0] ops[4] = '{8'h10, 8'h20, 8'h30, 8'h40};

      // reset state
      step(); step();
      @(negedge Clk);
      chk("rst_grant", Grant, 4'b0);
      chk("rst_accreset", Acc_Reset, 1'b1);
      step();
      Reset = 1'b1;

      // single job
      Req_Data[7:0] = 8'h05;
      Req = 4'b0001;
      t_req = cyc;
      wait_ack("t1", 60, t_ack);
      chk("t1_ack", Ack, 4'b0001);
      chk("t1_result", Result, 8'h1E);
      chk("t1_latency", t_ack - t_req, 8);
      chk("t1_accdata", Acc_Data, 8'h05);
      step();
      Req = '0;

      // contention after reset (Last=3 -> start at 0)
      step(); Reset = 1'b0;
      step(); Reset = 1'b1;
      gq.delete();
      for (int i = 0; i < 4; i++) Req_Data[i*8 +: 8] = ops[i];
      Req = 4'b1111;
      for (int j = 0; j < 5; j++) begin
         wait_ack("t2", 60, t_ack);
         own = 0;
         for (int b = 0; b < 4; b++) if (Ack[b]) own = b;
         chk("t2_owner", own, exp_ord[j]);
         chk("t2_result", Result, exp_res[j]);
      end
      step();
      Req = '0;
      chk("t2_njobs", gq.size(), 5);
      for (int j = 0; j < 5 && j < gq.size(); j++) chk("t2_grant_order", gq[j], exp_ord[j]);

      // stale Done: Done still high from previous job
      step();
      stale = 1'b1;
      Req_Data[15:8] = 8'h07;
      Req = 4'b0010;
      t_req = cyc;
      wait_ack("t3", 60, t_ack);
      chk("t3_ack", Ack, 4'b0010);
      chk("t3_latency", t_ack - t_req, 8);
      chk("t3_result", Result, 8'h2A);
      step();
      Req = '0;
      stale = 1'b0;

      // reset during WAIT, then Req[2] granted and dropped mid-job
      step();
      Req_Data[7:0] = 8'h09;
      Req = 4'b0001;
      repeat (4) step();
      Reset = 1'b0;
      @(negedge Clk);
      chk("t4_rst_grant", Grant, 4'b0);
      chk("t4_rst_load", Acc_Load, 1'b0);
      chk("t4_rst_data", Acc_Data, 8'h00);
      chk("t4_rst_result", Result, 8'h00);
      step();
      Req = 4'b0100;
      Req_Data[23:16] = 8'h0B;
      step();
      Reset = 1'b1;
      t_req = cyc;
      step();
      step();
      chk("t4_grant", Grant, 4'b0100);
      Req = '0;
      wait_ack("t4", 60, t_ack);
      chk("t4_ack", Ack, 4'b0100);
      chk("t4_result", Result, 8'h42);
      chk("t4_latency", t_ack - t_req, 8);
      step();

      // Done never rises
      acc_delay = 0;
      Req_Data[7:0] = 8'h33;
      Req = 4'b0001;
      t_req = cyc;
`ifdef ACC_ARB_TIMEOUT_EN
      wait_ack("t5", 40, t_ack);
      chk("t5_ack", Ack, 4'b0001);
      chk("t5_err", Err, 1'b1);
      chk("t5_result", Result, 8'h00);
      chk("t5_accreset", Acc_Reset, 1'b0);
      chk("t5_latency", t_ack - t_req, 10);
      step();
      Req = '0;
      @(negedge Clk);
      chk("t5_err_clr", Err, 1'b0);
      chk("t5_accreset_clr", Acc_Reset, 1'b1);
`else
      repeat (300) @(negedge Clk);
      chk("t5_hold_grant", Grant, 4'b0001);
      chk("t5_no_ack", Ack, 4'b0000);
`endif

      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end

endmodule

// File: doc/acc_job_arbiter.md
# acc_job_arbiter

Round-robin job arbiter that shares one 8-bit accumulator datapath (Load / Data_In / Done / ACC_Out handshake) among four requesters. Each requester posts a job operand; the arbiter grants one requester at a time, launches the accumulator, waits for completion, and returns the result with a one-cycle acknowledge. It sits between the requesting units and the accumulator and is the only driver of the accumulator's Load and Data_In.

## Interface
- DATA_W, 8: operand/result width
- TIMEOUT, 255: max WAIT cycles before abort (ACC_ARB_TIMEOUT_EN only); counter width = clog2(TIMEOUT+1)
- Clk  in  1  clock, rising edge
- Reset  in  1  one clock domain; reset is asynchronous, active-low
- Req  in  4  per-requester job request, level, held until its Ack
- Req_Data  in  4*DATA_W  packed operands, requester i at [i*DATA_W +: DATA_W]; held while Req[i]
- Grant  out  4  one-hot owner of the accumulator, 0 when idle
- Ack  out  4  one-cycle completion pulse to owner
- Result  out  DATA_W  result, valid in Ack cycle, held until next Ack
- Err  out  1  one-cycle pulse with Ack when job timed out
- Acc_Load  out  1  launch pulse to accumulator
- Acc_Data  out  DATA_W  operand to accumulator, stable for the whole job
- Acc_Reset  out  1  active-low reset to accumulator (timeout recovery)
- Acc_Done  in  1  accumulator completion level
- Acc_Out  in  DATA_W  accumulator result

## Operation
- States: IDLE, LOAD, WAIT, RESP. Reset: IDLE, Grant=0, Ack=0, Result=0, Err=0, Acc_Load=0, Acc_Data=0, Acc_Reset=1, Last=3, timeout count=0, Done_q=0.
- IDLE: if Req!=0, select first set bit searching (Last+1) mod 4 upward with wrap; register Grant, latch Acc_Data from selected Req_Data slice; -> LOAD. Else stay.
- LOAD: Acc_Load=1 for exactly this cycle; -> WAIT.
- WAIT: Acc_Load=0. Completion = rising edge of Acc_Done (Acc_Done & ~Done_q); a Done level left high from a previous job never completes a new job. On completion latch Result=Acc_Out; -> RESP.
- RESP: Ack[owner]=1 one cycle, Last=owner, Grant cleared at exit; -> IDLE.
- Requests arriving while not IDLE wait; no preemption. Req deasserted mid-job: job still completes, Ack still pulses.
- Grant bit stays set LOAD through RESP; Acc_Data unchanged from LOAD through RESP.
- Reset mid-job: everything returns to reset values immediately; no Ack for the aborted job.

## Timing
- Req seen in IDLE at cycle 0 -> Grant and Acc_Load high in cycle 1 -> WAIT from cycle 2.
- Acc_Done rising sampled at cycle d (d>=2) -> RESP/Ack/Result valid in cycle d+1 -> IDLE in d+2.
- Back-to-back: next grant earliest cycle d+3 (IDLE occupies one cycle).
- Fairness: with all Req high, grants rotate 0,1,2,3,0,...

## Configuration
- ACC_ARB_TIMEOUT_EN defined: counter cleared on LOAD, increments each WAIT cycle; when it equals TIMEOUT without completion -> RESP with Result=0, Err=1, Acc_Reset=0 for that one RESP cycle.
- Undefined: no counter, WAIT waits indefinitely, Err and Acc_Reset held constant (0 and 1).

## Test plan
- Single job: Req=0001, Req_Data[7:0]=0x05, model raises Acc_Done 6 cycles after Acc_Load with Acc_Out=0x1E -> Grant=0001 cycle 1, one Acc_Load pulse, Acc_Data=0x05, Ack=0001 with Result=0x1E one cycle after Done edge.
- Contention: Req=1111 held, operands 0x10,0x20,0x30,0x40 -> grant order 0,1,2,3,0; Acc_Data matches owner each job; exactly one Ack per job.
- Stale Done: Acc_Done left high from previous job -> new job does not complete until Done falls and rises again.
- Mid-job reset: Reset low during WAIT -> all outputs at reset values same cycle, no Ack; after release Req=0100 granted, Last=3 rule applies.
- Timeout (ACC_ARB_TIMEOUT_EN, TIMEOUT=8): Acc_Done never rises -> Ack, Err=1, Result=0, Acc_Reset low for one cycle, 8 WAIT cycles after LOAD; without macro, Grant holds indefinitely.
- Req drop: Req[2] deasserted during WAIT -> job completes, Ack=0100 still pulses, Result updated.
